// File: rtl/srp16_boot_pkg.sv
// Shared types and constants for the SRP16 byte-stream boot loader.
// Frame layout: MAGIC0 MAGIC1 LEN_LO LEN_HI {LO HI}*LEN CSUM.
package srp16_boot_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR1,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA_LO,
    ST_DATA_HI,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam logic [7:0] MAGIC0_DEF = 8'h5A;
  localparam logic [7:0] MAGIC1_DEF = 8'hA5;

  // Header (4 bytes) plus trailing checksum byte.
  localparam int unsigned FRAME_OVERHEAD = 5;

  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] dat);
    return sum + dat;
  endfunction

endpackage

// File: rtl/srp16_word_assembler.sv
// Pairs LO/HI bytes into a 16-bit word, keeps the running 8-bit data checksum and
// issues a one-cycle write the cycle after the high byte is accepted; never stalls.
module srp16_word_assembler
  import srp16_boot_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] LOAD_BASE  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            byte_dat,
  input  logic                  lo_vld,
  input  logic                  hi_vld,
  input  logic                  csum_clr,
  input  logic [ADDR_WIDTH-1:0] word_addr,
  output logic [7:0]            csum,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata
);

  logic [7:0]            lo_q,    lo_d;
  logic [7:0]            csum_q,  csum_d;
  logic                  we_q,    we_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  always_comb begin
    lo_d    = lo_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    if (csum_clr) begin
      csum_d = '0;
    end

    if (lo_vld) begin
      lo_d   = byte_dat;
      csum_d = csum_add(csum_q, byte_dat);
    end

    // Address and data are captured together so the write is self-contained.
    if (hi_vld) begin
      csum_d  = csum_add(csum_q, byte_dat);
      we_d    = 1'b1;
      addr_d  = word_addr;
      wdata_d = {byte_dat, lo_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q    <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= LOAD_BASE;
      wdata_q <= '0;
    end else begin
      lo_q    <= lo_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign csum      = csum_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: rtl/srp16_boot_loader.sv
// Frame-parsing boot loader: holds SRP16 in reset, loads a checksummed image, then releases it.
// Accepts one byte per cycle except in DONE/ERROR (in_ready low); word writes land one cycle after the HI byte.
module srp16_boot_loader
  import srp16_boot_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] LOAD_BASE  = '0,
  parameter logic [7:0]            MAGIC0     = MAGIC0_DEF,
  parameter logic [7:0]            MAGIC1     = MAGIC1_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  restart,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           word_count
);

  state_e      state_q, state_d;
  logic [15:0] length_q, length_d;
  logic [15:0] word_count_q, word_count_d;

  logic                  accept;
  logic                  lo_vld;
  logic                  hi_vld;
  logic                  csum_clr;
  logic [7:0]            csum;
  logic [ADDR_WIDTH-1:0] word_addr;

  assign in_ready  = (state_q != ST_DONE) && (state_q != ST_ERROR);
  assign accept    = in_valid && in_ready;
  assign word_addr = LOAD_BASE + ADDR_WIDTH'(word_count_q);

  always_comb begin
    state_d      = state_q;
    length_d     = length_q;
    word_count_d = word_count_q;
    lo_vld       = 1'b0;
    hi_vld       = 1'b0;
    csum_clr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Non-magic bytes are dropped silently so the loader can lock onto a frame mid-stream.
        if (accept && (in_data == MAGIC0)) begin
          state_d = ST_HDR1;
        end
      end
      ST_HDR1: begin
        if (accept) begin
          state_d = (in_data == MAGIC1) ? ST_LEN_LO : ST_ERROR;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          length_d[7:0] = in_data;
          state_d       = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          length_d[15:8] = in_data;
          csum_clr       = 1'b1;
          word_count_d   = '0;
          state_d        = ({in_data, length_q[7:0]} == 16'h0000) ? ST_CSUM : ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (accept) begin
          lo_vld  = 1'b1;
          state_d = ST_DATA_HI;
        end
      end
      ST_DATA_HI: begin
        if (accept) begin
          hi_vld       = 1'b1;
          word_count_d = word_count_q + 16'd1;
          state_d      = ((word_count_q + 16'd1) == length_q) ? ST_CSUM : ST_DATA_LO;
        end
      end
      ST_CSUM: begin
        if (accept) begin
          state_d = (in_data == csum) ? ST_DONE : ST_ERROR;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (restart) begin
          state_d      = ST_IDLE;
          word_count_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      length_q     <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      length_q     <= length_d;
      word_count_q <= word_count_d;
    end
  end

  srp16_word_assembler #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .LOAD_BASE (LOAD_BASE)
  ) u_asm (
    .clk      (clk),
    .rst_n    (reset),
    .byte_dat (in_data),
    .lo_vld   (lo_vld),
    .hi_vld   (hi_vld),
    .csum_clr (csum_clr),
    .word_addr(word_addr),
    .csum     (csum),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata)
  );

  // Core is released only by a verified image.
  assign cpu_reset  = (state_q != ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERROR);
  assign word_count = word_count_q;

endmodule

// File: tb/tb_srp16_boot_loader.sv
// Directed bench for srp16_boot_loader: one instance at base 0, one at base 0xFFFF, sharing stimulus.
module tb_srp16_boot_loader;
  import srp16_boot_pkg::*;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        restart;

  logic        in_ready0, mem_we0, cpu_reset0, done0, error0;
  logic [15:0] mem_addr0, mem_wdata0, word_count0;
  logic        in_ready1, mem_we1, cpu_reset1, done1, error1;
  logic [15:0] mem_addr1, mem_wdata1, word_count1;

  int n_tests = 0;
  int n_fail  = 0;

  wr_t wq0[$];
  wr_t wq1[$];
  bq_t fr;

  always #5 clk = ~clk;

  srp16_boot_loader #(.LOAD_BASE(16'h0000)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .restart(restart), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .cpu_reset(cpu_reset0), .done(done0), .error(error0), .word_count(word_count0)
  );

  srp16_boot_loader #(.LOAD_BASE(16'hFFFF)) dut_w (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .restart(restart), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .cpu_reset(cpu_reset1), .done(done1), .error(error1), .word_count(word_count1)
  );

  always @(negedge clk) begin
    if (mem_we0) wq0.push_back('{a: mem_addr0, d: mem_wdata0});
    if (mem_we1) wq1.push_back('{a: mem_addr1, d: mem_wdata1});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_wr(input string tag, input bit which, input int idx,
                          input logic [15:0] a, input logic [15:0] d);
    int  sz;
    wr_t w;
    sz = which ? wq1.size() : wq0.size();
    check({tag, "_present"}, 32'(sz > idx), 1);
    if (sz > idx) begin
      w = which ? wq1[idx] : wq0[idx];
      check({tag, "_addr"}, w.a, a);
      check({tag, "_data"}, w.d, d);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready0) check("rdy_timeout", in_ready0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input bq_t f, input bit gaps);
    foreach (f[i]) send_byte(f[i], gaps);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"},    mem_we0, 0);
    check({tag, "_addr"},  mem_addr0, 16'h0000);
    check({tag, "_waddr"}, mem_addr1, 16'hFFFF);
    check({tag, "_wdata"}, mem_wdata0, 16'h0000);
    check({tag, "_cpurst"}, cpu_reset0, 1);
    check({tag, "_done"},  done0, 0);
    check({tag, "_err"},   error0, 0);
    check({tag, "_wc"},    word_count0, 16'h0000);
    check({tag, "_rdy"},   in_ready0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    restart  = 1'b0;
    #12;
    check_reset_vals("rst");
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Good 2-word frame, back-to-back bytes; also exercises address wrap on dut_w.
    wq0.delete(); wq1.delete();
    fr = '{8'h5A, 8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h14};
    send_frame(fr, 1'b0);
    check("good_done",   done0, 1);
    check("good_cpurst", cpu_reset0, 0);
    check("good_err",    error0, 0);
    check("good_wc",     word_count0, 16'((fr.size() - FRAME_OVERHEAD) / 2));
    check("good_rdy",    in_ready0, 0);
    check("good_nwr",    wq0.size(), 2);
    check_wr("good_w0", 1'b0, 0, 16'h0000, 16'h1234);
    check_wr("good_w1", 1'b0, 1, 16'h0001, 16'h5678);
    check_wr("good_wrap0", 1'b1, 0, 16'hFFFF, 16'h1234);
    check_wr("good_wrap1", 1'b1, 1, 16'h0000, 16'h5678);

    // Restart back to IDLE, then a zero-length frame.
    pulse_restart();
    check("rs1_cpurst", cpu_reset0, 1);
    check("rs1_done",   done0, 0);
    check("rs1_wc",     word_count0, 0);
    check("rs1_rdy",    in_ready0, 1);
    wq0.delete(); wq1.delete();
    send_byte(8'h5A, 1'b0); send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    check("zl_pre_done", done0, 0);
    send_byte(8'h00, 1'b0);
    check("zl_done", done0, 1);
    check("zl_nwr",  wq0.size(), 0);
    check("zl_wc",   word_count0, 0);

    // Restart together with a valid byte: the byte must not be taken.
    in_data = 8'h5A; in_valid = 1'b1; restart = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; restart = 1'b0;
    check("sim_rdy",  in_ready0, 1);
    check("sim_done", done0, 0);
    send_byte(8'h00, 1'b0);
    check("sim_noerr", error0, 0);

    // Bad checksum: writes still happen, loader ends in ERROR.
    wq0.delete(); wq1.delete();
    fr = '{8'h5A, 8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h15};
    send_frame(fr, 1'b0);
    check("bad_err",    error0, 1);
    check("bad_done",   done0, 0);
    check("bad_cpurst", cpu_reset0, 1);
    check("bad_rdy",    in_ready0, 0);
    check("bad_nwr",    wq0.size(), 2);
    check_wr("bad_w1", 1'b0, 1, 16'h0001, 16'h5678);

    // Resync over junk bytes, then a 1-word frame.
    pulse_restart();
    check("rs2_err", error0, 0);
    wq0.delete(); wq1.delete();
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    check("sync_err", error0, 0);
    check("sync_rdy", in_ready0, 1);
    fr = '{8'h5A, 8'hA5, 8'h01, 8'h00, 8'hCD, 8'hAB, 8'h78};
    send_frame(fr, 1'b0);
    check("sync_done", done0, 1);
    check("sync_wc",   word_count0, 1);
    check_wr("sync_w0", 1'b0, 0, 16'h0000, 16'hABCD);

    // Bad second header byte.
    pulse_restart();
    send_byte(8'h5A, 1'b0); send_byte(8'h00, 1'b0);
    check("hdr_err", error0, 1);
    check("hdr_rdy", in_ready0, 0);

    // Wrap with irregular in_valid.
    pulse_restart();
    wq0.delete(); wq1.delete();
    fr = '{8'h5A, 8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h14};
    send_frame(fr, 1'b1);
    check("bp_done", done1, 1);
    check("bp_wc",   word_count1, 2);
    check("bp_nwr",  wq1.size(), 2);
    check_wr("bp_wrap0", 1'b1, 0, 16'hFFFF, 16'h1234);
    check_wr("bp_wrap1", 1'b1, 1, 16'h0000, 16'h5678);
    check_wr("bp_base1", 1'b0, 1, 16'h0001, 16'h5678);

    // Reset asserted right after the first write of a 3-word frame.
    pulse_restart();
    wq0.delete(); wq1.delete();
    fr = '{8'h5A, 8'hA5, 8'h03, 8'h00, 8'h11, 8'h22};
    send_frame(fr, 1'b0);
    @(negedge clk); #1;
    check("mid_we", mem_we0, 1);
    reset = 1'b0;
    #1;
    check_reset_vals("mid");
    in_data = 8'h33; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("mid_nwr", wq0.size(), 1);
    check_wr("mid_w0", 1'b0, 0, 16'h0000, 16'h2211);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    fr = '{8'h5A, 8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h14};
    send_frame(fr, 1'b0);
    check("post_done", done0, 1);
    check_wr("post_w1", 1'b0, 2, 16'h0001, 16'h5678);

    // Restart after DONE and load a second image.
    pulse_restart();
    check("rs3_cpurst", cpu_reset0, 1);
    check("rs3_wc",     word_count0, 0);
    wq0.delete(); wq1.delete();
    fr = '{8'h5A, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD};
    send_frame(fr, 1'b0);
    check("sec_done",   done0, 1);
    check("sec_cpurst", cpu_reset0, 0);
    check_wr("sec_w0", 1'b0, 0, 16'h0000, 16'hBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
